// File: rtl/cic_rate_ctrl_pkg.sv
// Shared definitions for the CIC decimator rate controller: controller state
// encoding and the rate-validity rule used when screening config requests.
package cic_rate_ctrl_pkg;

  // RUN passes data straight through.
  // WAIT_BOUNDARY waits for the next forwarded output so that a seamless change
  // lands on a clean decimation boundary.
  // FLUSH pulses the decimator reset for one cycle.
  // SETTLE drains the outputs that the comb stages corrupted after a rate change.
  typedef enum logic [1:0] {
    ST_RUN           = 2'd0,
    ST_WAIT_BOUNDARY = 2'd1,
    ST_FLUSH         = 2'd2,
    ST_SETTLE        = 2'd3
  } state_t;

  // A rate is usable when it is non-zero and no larger than the decimator's
  // maximum rate.
  function automatic logic rate_is_valid(input int unsigned rate,
                                         input int unsigned rmax);
    return (rate != 0) && (rate <= rmax);
  endfunction

endpackage

// File: rtl/cic_rate_ctrl.sv
// Rate controller placed in front of a CIC decimator. It accepts rate change
// requests over a ready/valid config port and applies them either by a
// one-cycle decimator reset (flush mode) or on the edge of a forwarded output,
// followed by discarding N*M outputs while the comb history settles (seamless
// mode). Data passes through combinationally whenever it is not being discarded.
// Typical integration drives the decimator reset with dec_rst | ~rst_n.
module cic_rate_ctrl
  import cic_rate_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RMAX      = 2,
  parameter int M         = 1,
  parameter int N         = 2,
  parameter int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N)
) (
  input  logic                         clk,
  input  logic                         rst_n,

  // Configuration request
  input  logic [$clog2(RMAX+1)-1:0]    cfg_rate,
  input  logic                         cfg_flush,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic                         cfg_error,

  // Decimator control
  output logic [$clog2(RMAX+1)-1:0]    dec_rate,
  output logic                         dec_rst,

  // Decimator result stream
  input  logic [REG_WIDTH-1:0]         dec_output_tdata,
  input  logic                         dec_output_tvalid,
  output logic                         dec_output_tready,

  // Downstream stream
  output logic [REG_WIDTH-1:0]         output_tdata,
  output logic                         output_tvalid,
  input  logic                         output_tready,

  output logic                         busy
);

  localparam int RATE_W = $clog2(RMAX + 1);
  localparam int CNT_W  = $clog2(N * M + 1);

  localparam logic [RATE_W-1:0] RATE_RESET   = RATE_W'(RMAX);
  localparam logic [CNT_W-1:0]  DISCARD_LOAD = CNT_W'(N * M);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);

  state_t              state_q,     state_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [RATE_W-1:0]   rate_q,      rate_d;
  logic [RATE_W-1:0]   pend_rate_q, pend_rate_d;
  logic                err_q,       err_d;
  logic                dec_rst_q,   dec_rst_d;

  logic                cfg_fire;
  logic                cfg_ok;
  logic                out_fire;

  // Handshake qualifiers used by the next-state logic.
  always_comb begin
    cfg_fire = cfg_valid && (state_q == ST_RUN);
    cfg_ok   = rate_is_valid(32'(cfg_rate), RMAX);
    out_fire = dec_output_tvalid && output_tready;
  end

  // Next-state, counter, rate and stream steering.
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    rate_d            = rate_q;
    pend_rate_d       = pend_rate_q;
    err_d             = 1'b0;
    cfg_ready         = 1'b0;
    // Pass-through is the default in every state except SETTLE.
    output_tdata      = dec_output_tdata;
    output_tvalid     = dec_output_tvalid;
    dec_output_tready = output_tready;

    case (state_q)
      ST_RUN: begin
        cfg_ready = 1'b1;
        if (cfg_fire) begin
          if (!cfg_ok) begin
            // Rejected requests are still consumed so the requester never stalls.
            err_d = 1'b1;
          end else begin
            pend_rate_d = cfg_rate;
            state_d     = cfg_flush ? ST_FLUSH : ST_WAIT_BOUNDARY;
          end
        end
      end

      ST_FLUSH: begin
        // dec_rst is high during this cycle; the new rate lands on the same edge
        // the decimator samples its reset, so it restarts cleanly at that rate.
        rate_d  = pend_rate_q;
        state_d = ST_RUN;
      end

      ST_WAIT_BOUNDARY: begin
        // The accepted output closes the last window at the old rate, so it is
        // forwarded and the rate is switched right behind it.
        if (out_fire) begin
          rate_d  = pend_rate_q;
          cnt_d   = DISCARD_LOAD;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // Outputs mixing old- and new-rate comb history are swallowed here.
        output_tvalid     = 1'b0;
        dec_output_tready = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_RUN;
        end else if (dec_output_tvalid) begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_SETTLE;
        cnt_d   = DISCARD_LOAD;
      end
    endcase

    // Registered so the decimator sees a glitch-free reset for the whole
    // FLUSH cycle.
    dec_rst_d = (state_d == ST_FLUSH);
  end

  // State register; reset parks the decimator at maximum rate and drains it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= DISCARD_LOAD;
      rate_q      <= RATE_RESET;
      pend_rate_q <= RATE_RESET;
      err_q       <= 1'b0;
      dec_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rate_q      <= rate_d;
      pend_rate_q <= pend_rate_d;
      err_q       <= err_d;
      dec_rst_q   <= dec_rst_d;
    end
  end

  // Registered status outputs.
  always_comb begin
    dec_rate  = rate_q;
    dec_rst   = dec_rst_q;
    cfg_error = err_q;
    busy      = (state_q != ST_RUN);
  end

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Self-checking bench for cic_rate_ctrl with RMAX=4, M=1, N=2.
// The bench plays the decimator by driving result beats directly; every beat
// that should reach the downstream port is queued and matched by a monitor.
module tb_cic_rate_ctrl;

  localparam int WIDTH     = 16;
  localparam int RMAX      = 4;
  localparam int M         = 1;
  localparam int N         = 2;
  localparam int REG_WIDTH = WIDTH + $clog2((RMAX * M) ** N);
  localparam int RW        = $clog2(RMAX + 1);

  logic                 clk;
  logic                 rst_n;
  logic [RW-1:0]        cfg_rate;
  logic                 cfg_flush;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_error;
  logic [RW-1:0]        dec_rate;
  logic                 dec_rst;
  logic [REG_WIDTH-1:0] dec_output_tdata;
  logic                 dec_output_tvalid;
  logic                 dec_output_tready;
  logic [REG_WIDTH-1:0] output_tdata;
  logic                 output_tvalid;
  logic                 output_tready;
  logic                 busy;

  int checks   = 0;
  int failures = 0;
  logic [REG_WIDTH-1:0] exp_q[$];

  cic_rate_ctrl #(
    .WIDTH(WIDTH), .RMAX(RMAX), .M(M), .N(N), .REG_WIDTH(REG_WIDTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_rate(cfg_rate),
    .cfg_flush(cfg_flush),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_error(cfg_error),
    .dec_rate(dec_rate),
    .dec_rst(dec_rst),
    .dec_output_tdata(dec_output_tdata),
    .dec_output_tvalid(dec_output_tvalid),
    .dec_output_tready(dec_output_tready),
    .output_tdata(output_tdata),
    .output_tvalid(output_tvalid),
    .output_tready(output_tready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decimator result beat; queued when it must appear downstream.
  task automatic beat(input logic [REG_WIDTH-1:0] d, input bit fwd);
    dec_output_tvalid = 1'b1;
    dec_output_tdata  = d;
    if (fwd) exp_q.push_back(d);
    tick();
    dec_output_tvalid = 1'b0;
  endtask

  // Downstream monitor: every accepted output must match the next queued beat.
  always @(negedge clk) begin
    if (output_tvalid === 1'b1 && output_tready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", output_tdata);
      end else begin
        check("sb_data", 32'(output_tdata), 32'(exp_q.pop_front()));
      end
    end
  end

  typedef struct {
    logic                 cv;
    logic [RW-1:0]        rate;
    logic                 dv;
    logic [REG_WIDTH-1:0] data;
    logic                 otr;
    logic                 e_otv;
    logic                 e_dtr;
    logic                 e_err;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // RUN-state vectors at rate 3: pass-through patterns and rejected rates.
    vecs[0] = '{1'b0, 3'd0, 1'b1, 20'h12345, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 3'd0, 1'b1, 20'hABCDE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 1'b0, 20'h00001, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 3'd0, 1'b1, 20'h55555, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 3'd0, 1'b0, 20'h00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd5, 1'b0, 20'h0AAAA, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 3'd7, 1'b1, 20'hFFFFF, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 3'd0, 1'b0, 20'h00002, 1'b1, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; cfg_valid = 1'b0; cfg_rate = '0; cfg_flush = 1'b0;
    dec_output_tvalid = 1'b0; dec_output_tdata = '0; output_tready = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_dec_rst", 32'(dec_rst), 32'd1);
    check("rst_dec_rate", 32'(dec_rate), 32'd4);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_cfg_error", 32'(cfg_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    dec_output_tvalid = 1'b1;
    #1;
    check("rst_out_tvalid", 32'(output_tvalid), 32'd0);
    check("rst_dec_tready", 32'(dec_output_tready), 32'd1);
    dec_output_tvalid = 1'b0;

    // Release: two outputs dropped, third forwarded
    rst_n = 1'b1;
    tick();
    check("rel_dec_rst", 32'(dec_rst), 32'd0);
    check("rel_busy", 32'(busy), 32'd1);
    beat(20'h00011, 1'b0);
    check("rel_busy_after1", 32'(busy), 32'd1);
    beat(20'h00012, 1'b0);
    check("rel_busy_after2", 32'(busy), 32'd0);
    check("rel_cfg_ready", 32'(cfg_ready), 32'd1);
    beat(20'h00013, 1'b1);

    // Flush to rate 3: one-cycle reset, no discard
    cfg_valid = 1'b1; cfg_rate = 3'd3; cfg_flush = 1'b1;
    #1;
    check("fl_cfg_ready_run", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check("fl_dec_rst", 32'(dec_rst), 32'd1);
    check("fl_busy", 32'(busy), 32'd1);
    check("fl_cfg_ready", 32'(cfg_ready), 32'd0);
    check("fl_rate_old", 32'(dec_rate), 32'd4);
    beat(20'h00041, 1'b1);
    check("fl_dec_rst_off", 32'(dec_rst), 32'd0);
    check("fl_rate_new", 32'(dec_rate), 32'd3);
    check("fl_busy_off", 32'(busy), 32'd0);

    // Table: pass-through and rejected requests in RUN
    for (int i = 0; i < 8; i++) begin
      cfg_valid = vecs[i].cv; cfg_rate = vecs[i].rate; cfg_flush = 1'b0;
      dec_output_tvalid = vecs[i].dv; dec_output_tdata = vecs[i].data;
      output_tready = vecs[i].otr;
      #1;
      check($sformatf("vec%0d_otvalid", i), 32'(output_tvalid), 32'(vecs[i].e_otv));
      check($sformatf("vec%0d_odata", i), 32'(output_tdata), 32'(vecs[i].data));
      check($sformatf("vec%0d_dtready", i), 32'(dec_output_tready), 32'(vecs[i].e_dtr));
      check($sformatf("vec%0d_cfg_ready", i), 32'(cfg_ready), 32'd1);
      if (vecs[i].dv && vecs[i].otr) exp_q.push_back(vecs[i].data);
      tick();
      check($sformatf("vec%0d_cfg_error", i), 32'(cfg_error), 32'(vecs[i].e_err));
      check($sformatf("vec%0d_rate", i), 32'(dec_rate), 32'd3);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
    end
    cfg_valid = 1'b0; dec_output_tvalid = 1'b0; output_tready = 1'b1;

    // Seamless 4 -> 2 mid-burst
    cfg_valid = 1'b1; cfg_rate = 3'd4; cfg_flush = 1'b1;
    tick();
    cfg_valid = 1'b0;
    tick();
    check("sm_rate4", 32'(dec_rate), 32'd4);
    beat(20'h00100, 1'b1);
    cfg_valid = 1'b1; cfg_rate = 3'd2; cfg_flush = 1'b0;
    beat(20'h00101, 1'b1);
    cfg_valid = 1'b0;
    check("sm_wait_busy", 32'(busy), 32'd1);
    check("sm_wait_cfg_ready", 32'(cfg_ready), 32'd0);
    check("sm_wait_rate", 32'(dec_rate), 32'd4);
    tick();
    check("sm_idle_rate", 32'(dec_rate), 32'd4);
    beat(20'h00102, 1'b1);
    check("sm_boundary_rate", 32'(dec_rate), 32'd2);
    check("sm_settle_busy", 32'(busy), 32'd1);
    beat(20'h00103, 1'b0);
    check("sm_settle_busy1", 32'(busy), 32'd1);
    beat(20'h00104, 1'b0);
    check("sm_settle_done", 32'(busy), 32'd0);
    beat(20'h00105, 1'b1);

    // Downstream stall during WAIT_BOUNDARY
    cfg_valid = 1'b1; cfg_rate = 3'd4; cfg_flush = 1'b0;
    tick();
    cfg_valid = 1'b0;
    output_tready = 1'b0; dec_output_tvalid = 1'b1; dec_output_tdata = 20'h00200;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_dtready", c), 32'(dec_output_tready), 32'd0);
      check($sformatf("stall%0d_otvalid", c), 32'(output_tvalid), 32'd1);
      tick();
      check($sformatf("stall%0d_rate", c), 32'(dec_rate), 32'd2);
      check($sformatf("stall%0d_cfg_ready", c), 32'(cfg_ready), 32'd0);
      check($sformatf("stall%0d_busy", c), 32'(busy), 32'd1);
    end
    output_tready = 1'b1;
    beat(20'h00200, 1'b1);
    check("stall_rate_applied", 32'(dec_rate), 32'd4);
    output_tready = 1'b0;
    #1;
    check("settle_dtready", 32'(dec_output_tready), 32'd1);
    beat(20'h00201, 1'b0);
    beat(20'h00202, 1'b0);
    check("stall_settle_done", 32'(busy), 32'd0);
    output_tready = 1'b1;

    // Reset during SETTLE with one discard pending
    cfg_valid = 1'b1; cfg_rate = 3'd1; cfg_flush = 1'b0;
    tick();
    cfg_valid = 1'b0;
    beat(20'h00300, 1'b1);
    check("mr_rate1", 32'(dec_rate), 32'd1);
    beat(20'h00301, 1'b0);
    check("mr_pending", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    check("mr_rate_reset", 32'(dec_rate), 32'd4);
    check("mr_dec_rst", 32'(dec_rst), 32'd1);
    rst_n = 1'b1;
    tick();
    beat(20'h00302, 1'b0);
    check("mr_cnt_reloaded", 32'(busy), 32'd1);
    beat(20'h00303, 1'b0);
    check("mr_settle_done", 32'(busy), 32'd0);
    beat(20'h00304, 1'b1);

    // Reset during WAIT_BOUNDARY drops the latched request
    cfg_valid = 1'b1; cfg_rate = 3'd2; cfg_flush = 1'b0;
    tick();
    cfg_valid = 1'b0;
    check("wr_wait_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    beat(20'h00400, 1'b0);
    beat(20'h00401, 1'b0);
    check("wr_rate_kept", 32'(dec_rate), 32'd4);
    check("wr_busy", 32'(busy), 32'd0);
    check("wr_cfg_ready", 32'(cfg_ready), 32'd1);

    tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cic_rate_ctrl.md
CIC_RATE_CTRL -- requirements
Module: cic_rate_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width, matching the decimator.
REQ-002 SHALL have parameter RMAX, default 2: maximum decimation rate.
REQ-003 SHALL have parameter M, default 1: comb differential delay.
REQ-004 SHALL have parameter N, default 2: stage count.
REQ-005 SHALL have parameter REG_WIDTH, default WIDTH+clog2((RMAX*M)**N): decimator output width.
REQ-006 SHALL have port clk, input, 1: sole clock. One clock; reset is synchronous and active-low.
REQ-007 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port cfg_rate, input, clog2(RMAX+1): requested rate.
REQ-009 SHALL have port cfg_flush, input, 1: 1 selects flush mode, 0 selects seamless mode.
REQ-010 SHALL have cfg_valid (input, 1) and cfg_ready (output, 1): config handshake.
REQ-011 SHALL have cfg_error, output, 1: one-cycle pulse when a request is rejected.
REQ-012 SHALL have dec_rate, output, clog2(RMAX+1): rate driven to the decimator.
REQ-013 SHALL have dec_rst, output, 1: active-high reset driven to the decimator.
REQ-014 SHALL have dec_output_tdata (input, REG_WIDTH) and dec_output_tvalid (input, 1): decimator result stream.
REQ-015 SHALL have dec_output_tready, output, 1: ready returned to the decimator.
REQ-016 SHALL have output_tdata (output, REG_WIDTH), output_tvalid (output, 1) and output_tready (input, 1): downstream stream.
REQ-017 SHALL have busy, output, 1: high in any state other than RUN.

Function
REQ-018 SHALL implement a FSM with states RUN, WAIT_BOUNDARY, FLUSH and SETTLE.
REQ-019 RUN: cfg_ready=1, pass-through: output_tdata=dec_output_tdata, output_tvalid=dec_output_tvalid, dec_output_tready=output_tready.
REQ-020 SHALL reject cfg_rate==0 or cfg_rate>RMAX: accept the handshake, pulse cfg_error next cycle, leave state and dec_rate unchanged.
REQ-021 SHALL latch a valid request with cfg_flush=1, then go to FLUSH.
REQ-022 SHALL latch a valid request with cfg_flush=0, then go to WAIT_BOUNDARY.
REQ-023 SHALL hold cfg_ready=0 in all states other than RUN.
REQ-024 FLUSH: assert dec_rst for exactly 1 cycle and load dec_rate with the latched rate on that same edge, then return to RUN; no outputs are discarded.
REQ-025 WAIT_BOUNDARY: keep pass-through active.
REQ-026 WAIT_BOUNDARY: on the cycle where dec_output_tvalid&output_tready, forward that sample and load dec_rate with the latched rate at that edge.
REQ-027 WAIT_BOUNDARY: on that same edge, load the discard counter with N*M and go to SETTLE.
REQ-028 SETTLE: dec_output_tready=1 and output_tvalid=0; each dec_output_tvalid beat decrements the counter.
REQ-029 SETTLE: go to RUN on the edge where the counter reaches 0.
REQ-030 A same-rate request SHALL still traverse the full sequence; there is no shortcut.
REQ-031 Config acceptance SHALL add zero cycles of data-path latency; pass-through SHALL be combinational.
REQ-032 The discard counter width SHALL be clog2(N*M+1).

Reset
REQ-033 While rst_n=0: state=SETTLE, counter=N*M, dec_rst=1, dec_rate=RMAX, cfg_ready=0, cfg_error=0, output_tvalid=0.
REQ-034 On the first cycle after release, dec_rst SHALL be 0; SETTLE then discards N*M outputs.
REQ-035 Reset asserted mid-sequence SHALL abandon the latched request; no partial rate SHALL be applied.

Structure
REQ-036 Shared package SHALL hold the state encoding and the rate-validity function.
REQ-037 The block SHALL be a single module.
REQ-038 Natural integration: a wrapper instantiating cic_decimator with rst=dec_rst|~rst_n.

Verification
REQ-039 Reset release, RMAX=4, M=1, N=2, rate 4 -> first 2 decimator outputs dropped, third forwarded, busy falls after the second.
REQ-040 Seamless change 4->2 mid-burst -> dec_rate changes on the edge of a forwarded output, exactly 2 outputs discarded, then output every 2 inputs.
REQ-041 Flush request rate 3 -> dec_rst high exactly 1 cycle, dec_rate=3 the next cycle, no discard, busy high 1 cycle.
REQ-042 cfg_rate=0, then cfg_rate=5 with RMAX=4 -> two cfg_error pulses, dec_rate unchanged, state RUN.
REQ-043 output_tready held 0 in WAIT_BOUNDARY -> no rate change, cfg_ready=0 throughout; rate applied on first accepted output after release.
REQ-044 rst_n asserted during SETTLE with 1 discard pending -> dec_rate=RMAX, counter reloaded to N*M, pending request dropped.
